// File: rtl/ps2_key_decoder.sv
// PS/2 scan code set 2 decoder: prefix handling, modifier tracking, US-layout
// ASCII translation and a show-ahead key FIFO for the CPU I/O port.
module ps2_key_decoder #(
    parameter int DEPTH = 16
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [7:0] scancode,
    input  logic       scancode_ready,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_read,
    output logic       shift_held,
    output logic       ctrl_held,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_SKIP
    } state_t;

    state_t     state, state_next;
    logic [2:0] skip_cnt, skip_next;
    logic       make_ev, break_ev, ev_ext;

    logic       lshift, rshift, lctrl, rctrl, caps_down;
    logic [5:0] letter;
    logic       trans_valid;
    logic [7:0] trans_byte;
    logic       push_valid;
    logic [7:0] push_byte;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en, drop;

    // Returns {hit, letter index 0..25} for the a-z make codes.
    function automatic logic [5:0] letter_lookup(input logic [7:0] code);
        case (code)
            8'h1C: return {1'b1, 5'd0};
            8'h32: return {1'b1, 5'd1};
            8'h21: return {1'b1, 5'd2};
            8'h23: return {1'b1, 5'd3};
            8'h24: return {1'b1, 5'd4};
            8'h2B: return {1'b1, 5'd5};
            8'h34: return {1'b1, 5'd6};
            8'h33: return {1'b1, 5'd7};
            8'h43: return {1'b1, 5'd8};
            8'h3B: return {1'b1, 5'd9};
            8'h42: return {1'b1, 5'd10};
            8'h4B: return {1'b1, 5'd11};
            8'h3A: return {1'b1, 5'd12};
            8'h31: return {1'b1, 5'd13};
            8'h44: return {1'b1, 5'd14};
            8'h4D: return {1'b1, 5'd15};
            8'h15: return {1'b1, 5'd16};
            8'h2D: return {1'b1, 5'd17};
            8'h1B: return {1'b1, 5'd18};
            8'h2C: return {1'b1, 5'd19};
            8'h3C: return {1'b1, 5'd20};
            8'h2A: return {1'b1, 5'd21};
            8'h1D: return {1'b1, 5'd22};
            8'h22: return {1'b1, 5'd23};
            8'h35: return {1'b1, 5'd24};
            8'h1A: return {1'b1, 5'd25};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic is_noise(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
               (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        if (scancode_ready) begin
            case (state)
                ST_IDLE: begin
                    if (scancode == 8'hE0) begin
                        state_next = ST_EXT;
                    end else if (scancode == 8'hF0) begin
                        state_next = ST_BRK;
                    end else if (scancode == 8'hE1) begin
                        state_next = ST_SKIP;
                        skip_next  = 3'd7;
                    end
                end
                ST_EXT:            state_next = (scancode == 8'hF0) ? ST_EXTBRK : ST_IDLE;
                ST_BRK, ST_EXTBRK: state_next = ST_IDLE;
                ST_SKIP: begin
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_next = ST_IDLE;
                end
                default:           state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        make_ev  = 1'b0;
        break_ev = 1'b0;
        ev_ext   = 1'b0;
        if (scancode_ready) begin
            case (state)
                ST_IDLE: make_ev = !((scancode == 8'hE0) || (scancode == 8'hF0) ||
                                     (scancode == 8'hE1) || is_noise(scancode));
                ST_EXT: begin
                    make_ev = (scancode != 8'hF0);
                    ev_ext  = 1'b1;
                end
                ST_BRK: break_ev = 1'b1;
                ST_EXTBRK: begin
                    break_ev = 1'b1;
                    ev_ext   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Caps toggles only on the first make; typematic repeats see caps_down=1.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            caps_down <= 1'b0;
            caps_lock <= 1'b0;
        end else if (make_ev || break_ev) begin
            if (!ev_ext && scancode == 8'h12) lshift <= make_ev;
            if (!ev_ext && scancode == 8'h59) rshift <= make_ev;
            if (scancode == 8'h14) begin
                if (ev_ext) rctrl <= make_ev;
                else        lctrl <= make_ev;
            end
            if (!ev_ext && scancode == 8'h58) begin
                if (make_ev && !caps_down) caps_lock <= !caps_lock;
                caps_down <= make_ev;
            end
        end
    end

    assign shift_held = lshift | rshift;
    assign ctrl_held  = lctrl | rctrl;

    always_comb begin
        letter      = letter_lookup(scancode);
        trans_valid = 1'b0;
        trans_byte  = 8'h00;
        if (make_ev) begin
            trans_valid = 1'b1;
            if (!ev_ext && letter[5]) begin
                if (ctrl_held)                   trans_byte = {3'b000, letter[4:0]} + 8'd1;
                else if (shift_held ^ caps_lock) trans_byte = 8'h41 + {3'b000, letter[4:0]};
                else                             trans_byte = 8'h61 + {3'b000, letter[4:0]};
            end else begin
                case ({ev_ext, scancode})
                    9'h016: trans_byte = shift_held ? "!" : "1";
                    9'h01E: trans_byte = shift_held ? "@" : "2";
                    9'h026: trans_byte = shift_held ? "#" : "3";
                    9'h025: trans_byte = shift_held ? "$" : "4";
                    9'h02E: trans_byte = shift_held ? "%" : "5";
                    9'h036: trans_byte = shift_held ? "^" : "6";
                    9'h03D: trans_byte = shift_held ? "&" : "7";
                    9'h03E: trans_byte = shift_held ? "*" : "8";
                    9'h046: trans_byte = shift_held ? "(" : "9";
                    9'h045: trans_byte = shift_held ? ")" : "0";
                    9'h029: trans_byte = 8'h20;
                    9'h05A, 9'h15A: trans_byte = 8'h0D;
                    9'h066: trans_byte = 8'h08;
                    9'h00D: trans_byte = 8'h09;
                    9'h076: trans_byte = 8'h1B;
                    9'h175: trans_byte = 8'h80;
                    9'h172: trans_byte = 8'h81;
                    9'h16B: trans_byte = 8'h82;
                    9'h174: trans_byte = 8'h83;
                    default: trans_valid = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            push_valid <= 1'b0;
            push_byte  <= 8'h00;
        end else begin
            push_valid <= trans_valid;
            push_byte  <= trans_byte;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = key_read && !empty;
    assign wr_en = push_valid && (!full || pop);
    assign drop  = push_valid && full && !pop;

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_byte;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (drop)     overflow <= 1'b1;
            else if (pop) overflow <= 1'b0;
        end
    end

    assign key_valid = !empty;
    assign key_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by a
// random byte stream compared against a queue-based keyboard model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       scancode_ready = 1'b0;
    logic       key_read = 1'b0;
    logic [7:0] key_data;
    logic       key_valid, shift_held, ctrl_held, caps_lock, overflow;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] q[$];
    bit m_ovf, m_lsh, m_rsh, m_lctl, m_rctl, m_caps, m_caps_dn, m_ext, m_brk;
    int m_skip;

    int letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    int digit_codes[10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    string digit_plain = "1234567890";
    string digit_shift = "!@#$%^&*()";
    int pool[28] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h16, 8'h1E, 8'h45, 8'h29, 8'h5A, 8'h66,
                     8'h0D, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h59, 8'h14, 8'h58,
                     8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'h77, 8'h4A, 8'hF0};

    ps2_key_decoder #(.DEPTH(DEPTH)) dut (
        .CLOCK_50       (clk),
        .rst_n          (rst_n),
        .scancode       (scancode),
        .scancode_ready (scancode_ready),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_read       (key_read),
        .shift_held     (shift_held),
        .ctrl_held      (ctrl_held),
        .caps_lock      (caps_lock),
        .overflow       (overflow)
    );

    always #10 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        {m_ovf, m_lsh, m_rsh, m_lctl, m_rctl, m_caps, m_caps_dn, m_ext, m_brk} = '0;
        m_skip = 0;
    endtask

    task automatic model_translate(input logic [7:0] code, input bit ext,
                                   output bit has, output logic [7:0] val);
        bit shift, ctrl;
        shift = m_lsh | m_rsh;
        ctrl  = m_lctl | m_rctl;
        has = 1'b0;
        val = 8'h00;
        if (!ext) begin
            for (int i = 0; i < 26; i++) begin
                if (letter_codes[i] == int'(code)) begin
                    has = 1'b1;
                    if (ctrl)               val = 8'(i + 1);
                    else if (shift ^ m_caps) val = 8'(8'h41 + i);
                    else                    val = 8'(8'h61 + i);
                end
            end
            for (int i = 0; i < 10; i++) begin
                if (digit_codes[i] == int'(code)) begin
                    has = 1'b1;
                    val = shift ? digit_shift[i] : digit_plain[i];
                end
            end
            case (code)
                8'h29: begin has = 1'b1; val = 8'h20; end
                8'h66: begin has = 1'b1; val = 8'h08; end
                8'h0D: begin has = 1'b1; val = 8'h09; end
                8'h76: begin has = 1'b1; val = 8'h1B; end
                default: ;
            endcase
        end else begin
            case (code)
                8'h75: begin has = 1'b1; val = 8'h80; end
                8'h72: begin has = 1'b1; val = 8'h81; end
                8'h6B: begin has = 1'b1; val = 8'h82; end
                8'h74: begin has = 1'b1; val = 8'h83; end
                default: ;
            endcase
        end
        if (code == 8'h5A) begin
            has = 1'b1;
            val = 8'h0D;
        end
    endtask

    // Applies one received byte to the model; reports the translated key if any.
    task automatic model_byte(input logic [7:0] b, output bit has, output logic [7:0] val);
        bit ext, brk, mk;
        has = 1'b0;
        val = 8'h00;
        if (m_skip > 0) begin
            m_skip--;
        end else if (!m_ext && !m_brk && b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!m_ext && !m_brk && b == 8'hE1) begin
            m_skip = 7;
        end else if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            has = 1'b0;
        end else begin
            ext = m_ext;
            brk = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
            mk = !brk;
            if (mk) model_translate(b, ext, has, val);
            if (!ext && b == 8'h12) m_lsh = mk;
            if (!ext && b == 8'h59) m_rsh = mk;
            if (b == 8'h14) begin
                if (ext) m_rctl = mk;
                else     m_lctl = mk;
            end
            if (!ext && b == 8'h58) begin
                if (mk && !m_caps_dn) m_caps = !m_caps;
                m_caps_dn = mk;
            end
        end
    endtask

    task automatic model_fifo(input bit has, input logic [7:0] val, input bit rd);
        bit pop_ok, dropped;
        pop_ok  = rd && (q.size() > 0);
        dropped = 1'b0;
        if (pop_ok) void'(q.pop_front());
        if (has) begin
            if (q.size() == DEPTH) dropped = 1'b1;
            else                   q.push_back(val);
        end
        if (dropped)     m_ovf = 1'b1;
        else if (pop_ok) m_ovf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        check({tag, ":key_valid"}, 8'(key_valid), 8'(q.size() > 0));
        check({tag, ":key_data"},  key_data, head);
        check({tag, ":shift"},     8'(shift_held), 8'(m_lsh | m_rsh));
        check({tag, ":ctrl"},      8'(ctrl_held), 8'(m_lctl | m_rctl));
        check({tag, ":caps"},      8'(caps_lock), 8'(m_caps));
        check({tag, ":overflow"},  8'(overflow), 8'(m_ovf));
    endtask

    // Strobe one byte; optionally pulse key_read in the cycle its key is written.
    task automatic send_byte(input logic [7:0] b, input bit rd);
        bit has;
        logic [7:0] val;
        @(posedge clk); #1;
        scancode = b;
        scancode_ready = 1'b1;
        @(posedge clk); #1;
        scancode_ready = 1'b0;
        key_read = rd;
        @(posedge clk); #1;
        key_read = 1'b0;
        model_byte(b, has, val);
        model_fifo(has, val, rd);
    endtask

    task automatic pop_key();
        @(posedge clk); #1;
        key_read = 1'b1;
        @(posedge clk); #1;
        key_read = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit has;
        logic [7:0] val;
        logic [7:0] seq_pause[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Reset state
        model_reset();
        do_reset();
        check_all("reset");
        check("reset:key_data_zero", key_data, 8'h00);

        // Single key, latency, release
        @(posedge clk); #1;
        scancode = 8'h1C;
        scancode_ready = 1'b1;
        @(posedge clk); #1;
        scancode_ready = 1'b0;
        check("lat:n1_valid", 8'(key_valid), 8'h00);
        @(posedge clk); #1;
        check("lat:n2_valid", 8'(key_valid), 8'h01);
        model_byte(8'h1C, has, val);
        model_fifo(has, val, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_all("t1");
        check("t1:head", key_data, 8'h61);
        pop_key();
        check("t1:empty", 8'(key_valid), 8'h00);

        // Shift
        send_byte(8'h12, 1'b0);
        check("t2:shift_on", 8'(shift_held), 8'h01);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        check("t2:shift_off", 8'(shift_held), 8'h00);
        send_byte(8'h1C, 1'b0);
        check_all("t2");
        check("t2:first", key_data, 8'h41);
        pop_key();
        check("t2:second", key_data, 8'h61);
        pop_key();

        // Caps lock with typematic repeat
        send_byte(8'h58, 1'b0);
        check("t3:caps_first", 8'(caps_lock), 8'h01);
        send_byte(8'h58, 1'b0);
        check("t3:caps_repeat", 8'(caps_lock), 8'h01);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h58, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_all("t3");
        check("t3:first", key_data, 8'h41);
        pop_key();
        check("t3:second", key_data, 8'h61);
        pop_key();
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);

        // Right ctrl, extended arrow, Pause sequence, digit
        send_byte(8'hE0, 1'b0);
        send_byte(8'h14, 1'b0);
        check("t4:ctrl_on", 8'(ctrl_held), 8'h01);
        send_byte(8'h21, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        foreach (seq_pause[i]) send_byte(seq_pause[i], 1'b0);
        send_byte(8'h16, 1'b0);
        check_all("t4");
        check("t4:ctrl_off", 8'(ctrl_held), 8'h00);
        check("t4:k0", key_data, 8'h03);
        pop_key();
        check("t4:k1", key_data, 8'h80);
        pop_key();
        check("t4:k2", key_data, 8'h31);
        pop_key();
        check("t4:empty", 8'(key_valid), 8'h00);

        // Overflow, then coincident push and pop while full
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h1C, 1'b0);
            send_byte(8'hF0, 1'b0);
            send_byte(8'h1C, 1'b0);
        end
        check_all("t5:full");
        check("t5:overflow_set", 8'(overflow), 8'h01);
        send_byte(8'h1C, 1'b1);
        check_all("t5:pushpop");
        check("t5:overflow_clr", 8'(overflow), 8'h00);
        check("t5:model_count", 8'(q.size()), 8'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("t5:drain_head", key_data, q[0]);
            pop_key();
        end
        check_all("t5:drained");
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);

        // Reset mid-sequence discards the partial prefix
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        do_reset();
        send_byte(8'h75, 1'b0);
        check_all("t6");
        check("t6:valid", 8'(key_valid), 8'h00);
        check("t6:caps", 8'(caps_lock), 8'h00);

        // Random byte stream against the model
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                do_reset();
            end else if (sel < 20) begin
                pop_key();
            end else begin
                send_byte(8'(pool[$urandom_range(0, 27)]), $urandom_range(0, 3) == 0);
            end
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Consumes the byte stream from the PS/2 receiver (8-bit scancode plus one-cycle ready strobe) and interprets scan code set 2: E0/F0 prefixes, E1 Pause sequence, modifier tracking and US-layout ASCII translation. Translated key presses are queued in a show-ahead FIFO that the CPU I/O port pops one byte at a time. Modifier and overflow status is exported for the memory-mapped status register.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)

Ports:
CLOCK_50  in  1  system clock
rst_n  in  1  synchronous reset, active-low
scancode  in  8  byte from PS/2 receiver
scancode_ready  in  1  one-cycle strobe; scancode valid this cycle
key_data  out  8  FIFO head byte; valid when key_valid=1
key_valid  out  1  FIFO non-empty
key_read  in  1  pop head; ignored when key_valid=0
shift_held  out  1  either shift currently down
ctrl_held  out  1  either ctrl currently down
caps_lock  out  1  caps lock toggle state
overflow  out  1  sticky; a key was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0 at a CLOCK_50 edge): FIFO empty, key_valid=0, key_data=0, shift_held=0, ctrl_held=0, caps_lock=0, overflow=0, prefix FSM=IDLE, skip counter=0, internal caps_down=0. Reset mid-sequence discards any partial prefix.
- Prefix FSM, advanced only on scancode_ready:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP (count=7); AA/FA/FE/EE/00/FF ignored, stay IDLE; other -> make(code, ext=0).
  - EXT: F0->EXTBRK; else make(code, ext=1) -> IDLE.
  - BRK: break(code, ext=0) -> IDLE.
  - EXTBRK: break(code, ext=1) -> IDLE.
  - SKIP: decrement count; -> IDLE when count reaches 0. Consumes exactly the 7 bytes following E1.
- Modifiers: left shift 12 / right shift 59 tracked by separate bits; shift_held=OR. Ctrl: 14 (ext=0 left, ext=1 right); ctrl_held=OR. Break clears the corresponding bit. Caps 58: make while caps_down=0 toggles caps_lock and sets caps_down; break clears caps_down, so typematic repeats do not re-toggle. Modifier keys never enqueue.
- Translation on make only (break never enqueues):
  - Letters a-z: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A. Uppercase when shift_held XOR caps_lock. If ctrl_held: 0x01-0x1A regardless of case.
  - Digits 1-9,0: 16,1E,26,25,2E,36,3D,3E,46,45. Shifted: ! @ # $ % ^ & * ( ). Caps lock has no effect.
  - 29 space 0x20; 5A enter 0x0D (ext=0 or 1); 66 backspace 0x08; 0D tab 0x09; 76 esc 0x1B.
  - Ext arrows: 75 up 0x80, 72 down 0x81, 6B left 0x82, 74 right 0x83.
  - Anything else is dropped silently.
  - Modifier state used is the value before the current byte.
- Latency: strobe in cycle N -> registered translation in N+1 -> FIFO write at the end of N+1 -> key_valid/key_data updated in N+2.
- FIFO: show-ahead, pointer width clog2(DEPTH)+1 for full/empty.
  - Pop on key_read & key_valid; key_data shows the next entry the following cycle.
  - Push while full without simultaneous pop: byte dropped, overflow<=1.
  - Push and pop in the same cycle when full: both accepted, count unchanged.
  - Push while empty: pop is ignored.
  - Pointers wrap modulo DEPTH.
- overflow clears on the first accepted pop after being set. If the same cycle also drops a byte, overflow stays 1.

Test Plan:
- Strobes 1C then F0 1C -> exactly one entry 0x61; key_valid rises 2 cycles after the 1C strobe; FIFO empty after one key_read.
- 12, 1C, F0 12, 1C -> entries 0x41, 0x61; shift_held 1 then 0.
- 58, 58 (repeat), F0 58, 1C, then 12, 1C -> caps_lock=1 after first 58 only; entries 0x41, then 0x61 (shift XOR caps).
- E0 14, 21, E0 F0 14, E0 75, E1 14 77 E1 F0 14 F0 77, 16 -> entries 0x03, 0x80, 0x31; ctrl_held returns 0; Pause bytes produce nothing.
- 17 presses of 1C with DEPTH=16 and no reads -> 16 entries, overflow=1. Then a key_read coincident with one more push -> count stays 16, overflow=0.
- Assert rst_n=0 after E0 F0 mid-sequence, release, send 75 -> entry 0x48? no: plain 75 is unmapped, FIFO stays empty, all status outputs 0.
